// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for the pipelined adder: slice-width derivation and the
// parameter legality check used at elaboration.
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_STAGES = 2;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && (stages <= width) &&
           ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Streaming operand/result bus of the pipelined adder: valid/ready on both
// the operand side and the result side.
interface pipelined_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, s, co, ovf
  );
endinterface

// File: rtl/adder_slice.sv
// Combinational CW-bit ripple of full-adder cells; also exposes the carry
// into the slice MSB so the top slice can derive signed overflow.
module adder_slice #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] s,
  output logic          cout,
  output logic          c_msb_in
);

  logic [CW:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int k = 0; k < CW; k++) begin
      s[k]   = a[k] ^ b[k] ^ c[k];
      c[k+1] = (a[k] & b[k]) | (c[k] & (a[k] ^ b[k]));
    end
  end

  assign cout     = c[CW];
  assign c_msb_in = c[CW-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder/subtractor with the carry chain cut into STAGES registered
// slices; valid/ready flow control with a combinational ready chain.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input logic              clk,
  input logic              rst_n,
  pipelined_adder_if.slave bus
);

  localparam int CW = slice_width(WIDTH, STAGES);
  localparam int L  = STAGES - 1;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be >= 1 and divisible by STAGES (1..WIDTH)");
  end

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  opa_q [STAGES];
  logic [WIDTH-1:0]  opa_d [STAGES];
  logic [WIDTH-1:0]  opb_q [STAGES];
  logic [WIDTH-1:0]  opb_d [STAGES];
  logic              cmsb_q, cmsb_d;

  logic [STAGES:0]   adv;
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [WIDTH-1:0]  src_sum [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;

  logic [CW-1:0]     slice_s  [STAGES];
  logic              slice_co [STAGES];
  logic              slice_cm [STAGES];

  // Ready ripples from the output back to the input within one cycle.
  always_comb begin
    adv         = '0;
    adv[STAGES] = bus.out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i] = !v_q[i] || adv[i+1];
    end
  end

  // Stage 0 consumes the bus; later stages consume the previous stage.
  // Subtraction is folded in here as a + ~b + 1.
  always_comb begin
    src_a[0]   = bus.a;
    src_b[0]   = bus.sub ? ~bus.b : bus.b;
    src_c[0]   = bus.sub | bus.ci;
    src_sum[0] = '0;
    src_v[0]   = bus.in_valid;
    for (int i = 1; i < STAGES; i++) begin
      src_a[i]   = opa_q[i-1];
      src_b[i]   = opb_q[i-1];
      src_c[i]   = carry_q[i-1];
      src_sum[i] = sum_q[i-1];
      src_v[i]   = v_q[i-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_slice
    adder_slice #(.CW(CW)) u_slice (
      .a        (src_a[g][g*CW +: CW]),
      .b        (src_b[g][g*CW +: CW]),
      .cin      (src_c[g]),
      .s        (slice_s[g]),
      .cout     (slice_co[g]),
      .c_msb_in (slice_cm[g])
    );
  end

  always_comb begin
    v_d     = v_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    for (int i = 0; i < STAGES; i++) begin
      sum_d[i] = sum_q[i];
      opa_d[i] = opa_q[i];
      opb_d[i] = opb_q[i];
    end
    // Data registers only move with a real item; a bubble just clears v.
    for (int i = 0; i < STAGES; i++) begin
      if (adv[i]) begin
        v_d[i] = src_v[i];
        if (src_v[i]) begin
          opa_d[i]              = src_a[i];
          opb_d[i]              = src_b[i];
          carry_d[i]            = slice_co[i];
          sum_d[i]              = src_sum[i];
          sum_d[i][i*CW +: CW]  = slice_s[i];
        end
      end
    end
    if (adv[L] && src_v[L]) begin
      cmsb_d = slice_cm[L];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      carry_q <= '0;
      cmsb_q  <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        sum_q[i] <= '0;
        opa_q[i] <= '0;
        opb_q[i] <= '0;
      end
    end else begin
      v_q     <= v_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      for (int i = 0; i < STAGES; i++) begin
        sum_q[i] <= sum_d[i];
        opa_q[i] <= opa_d[i];
        opb_q[i] <= opb_d[i];
      end
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = v_q[L];
  assign bus.s         = sum_q[L];
  assign bus.co        = carry_q[L];
  assign bus.ovf       = cmsb_q ^ carry_q[L];

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=8, STAGES=2): arithmetic-level
// reference queue checked every output cycle, plus literal expectations.
module tb_pipelined_adder;

  localparam int W  = 8;
  localparam int ST = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(W)) bus ();

  pipelined_adder #(.WIDTH(W), .STAGES(ST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [9:0] exp_q[$];
  logic [7:0] retired[$];
  int         ov_run  = 0;
  int         max_run = 0;

  // Result as {ovf, co, s} from plain integer arithmetic.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic ci, input logic sub);
    int ua, ub, sa, sb, u, sv;
    logic [7:0] s;
    logic co, ov;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      u  = ua - ub;
      sv = sa - sb;
      co = (ua >= ub);
    end else begin
      u  = ua + ub + int'(ci);
      sv = sa + sb + int'(ci);
      co = (u > 255);
    end
    s  = u[7:0];
    ov = (sv > 127) || (sv < -128);
    return {ov, co, s};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      ov_run = 0;
    end else begin
      if (bus.out_valid === 1'b1) begin
        ov_run++;
        if (ov_run > max_run) max_run = ov_run;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: out_valid=1 s=0x%0h with no result outstanding", bus.s);
        end else begin
          chk("model_result", 32'({bus.ovf, bus.co, bus.s}), 32'(exp_q[0]));
          if (bus.out_ready) begin
            retired.push_back(bus.s);
            void'(exp_q.pop_front());
          end
        end
      end else begin
        ov_run = 0;
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.a, bus.b, bus.ci, bus.sub));
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub);
    bit acc;
    acc          = 1'b0;
    bus.a        = a;
    bus.b        = b;
    bus.ci       = ci;
    bus.sub      = sub;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=0 for 50 cycles, required 1");
    end
  endtask

  task automatic expect_pulse(input string name, input logic [7:0] s,
                              input logic co, input logic ovf);
    @(negedge clk);
    chk({name, "_early"}, 32'(bus.out_valid), 32'(1'b0));
    @(negedge clk);
    chk({name, "_valid"}, 32'(bus.out_valid), 32'(1'b1));
    chk({name, "_s"},     32'(bus.s),         32'(s));
    chk({name, "_co"},    32'(bus.co),        32'(co));
    chk({name, "_ovf"},   32'(bus.ovf),       32'(ovf));
    @(negedge clk);
    chk({name, "_pulse"}, 32'(bus.out_valid), 32'(1'b0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, mark, stalls;
    bit acc;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.ci        = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;

    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'(1'b0));
    chk("rst_s",         32'(bus.s),         32'(8'h00));
    chk("rst_co",        32'(bus.co),        32'(1'b0));
    chk("rst_ovf",       32'(bus.ovf),       32'(1'b0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'(1'b1));
    @(posedge clk);
    #1;

    send(8'h0F, 8'h01, 1'b0, 1'b0); expect_pulse("add_0f_01", 8'h10, 1'b0, 1'b0);
    send(8'hFF, 8'h01, 1'b0, 1'b0); expect_pulse("add_ff_01", 8'h00, 1'b1, 1'b0);
    send(8'h7F, 8'h00, 1'b1, 1'b0); expect_pulse("add_7f_ci", 8'h80, 1'b0, 1'b1);
    send(8'h05, 8'h07, 1'b1, 1'b1); expect_pulse("sub_05_07", 8'hFE, 1'b0, 1'b0);
    send(8'h80, 8'h01, 1'b1, 1'b1); expect_pulse("sub_80_01", 8'h7F, 1'b1, 1'b1);

    // Backpressure: pipe fills to two, holds, then drains in order.
    bus.out_ready = 1'b0;
    bus.ci        = 1'b0;
    bus.sub       = 1'b0;
    idx           = 0;
    mark          = retired.size();
    for (int c = 0; c < 6; c++) begin
      bus.a        = 8'(idx + 1);
      bus.b        = 8'(idx + 1);
      bus.in_valid = 1'b1;
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    @(negedge clk);
    chk("bp_in_ready",  32'(bus.in_ready),  32'(1'b0));
    chk("bp_out_valid", 32'(bus.out_valid), 32'(1'b1));
    chk("bp_hold_s",    32'(bus.s),         32'(8'h02));
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      bus.a        = 8'(idx + 1);
      bus.b        = 8'(idx + 1);
      bus.in_valid = 1'b1;
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("bp_count", 32'(retired.size() - mark), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (retired.size() > mark + k)
        chk("bp_order", 32'(retired[mark + k]), 32'(2 * (k + 1)));
    end

    // Full throughput: 16 back-to-back random additions.
    max_run = 0;
    stalls  = 0;
    for (int k = 0; k < 16; k++) begin
      bus.a        = 8'($urandom);
      bus.b        = 8'($urandom);
      bus.ci       = 1'($urandom_range(0, 1));
      bus.sub      = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      if (!bus.in_ready) stalls++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("tput_stalls", 32'(stalls),  32'd0);
    chk("tput_run",    32'(max_run), 32'd16);

    // Reset with two results in flight.
    idx     = 0;
    bus.ci  = 1'b0;
    bus.sub = 1'b0;
    for (int c = 0; c < 10 && idx < 2; c++) begin
      bus.a        = 8'h11 + 8'(idx);
      bus.b        = 8'h22;
      bus.in_valid = 1'b1;
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
    chk("rf_pre_valid", 32'(bus.out_valid), 32'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("rf_out_valid", 32'(bus.out_valid), 32'(1'b0));
    chk("rf_s",         32'(bus.s),         32'(8'h00));
    chk("rf_co",        32'(bus.co),        32'(1'b0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rf_stale", 32'(bus.out_valid), 32'(1'b0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor.
- Successor to the single-bit full adder: generalises to WIDTH bits, splits the carry chain into STAGES registered slices, and adds a subtract mode.
- Uses valid/ready flow control with backpressure so it can sit in streaming datapaths; one result per clock at full throughput.

Parameters:
- WIDTH, 8, operand/sum width in bits; must be >= 1 and divisible by STAGES.
- STAGES, 2, number of pipeline stages (carry-chain slices); 1..WIDTH; slice width CW = WIDTH/STAGES.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block can accept an operand set this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: s = a + b + ci; 1: s = a - b, computed as a + ~b + 1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- s  out  WIDTH  sum/difference, modulo 2^WIDTH.
- co  out  1  carry-out of MSB; in subtract mode co = 1 means no borrow (a >= b unsigned).
- ovf  out  1  signed two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n=0, asynchronous): all stage valid bits clear; out_valid=0, s=0, co=0, ovf=0. in_ready=1 once rst_n is high.
- Transfer rules: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Stage i (0..STAGES-1) holds:
  - valid bit v[i];
  - registered sum bits for slices 0..i;
  - registered carry out of slice i;
  - the unconsumed upper operand bits (a, and b already inverted when sub=1);
  - MSB carry-in when i = STAGES-1.
- Slice i adds operand bits [i*CW +: CW] with the carry from stage i-1; stage 0 uses the effective carry-in (sub ? 1 : ci).
- Advance condition: stage i loads when !v[i] || adv[i+1]. The last stage loads when !v[last] || out_ready. in_ready = adv[0]. The ready path is combinational back through the stages.
- Latency: result for an accepted operand set is presented on out_valid exactly STAGES cycles after acceptance when unstalled.
- Throughput: 1 per cycle when out_ready is held high.
- Output hold: outputs (s, co, ovf) come straight from the last stage registers and remain stable while out_valid=1 && out_ready=0.
- Bubbles: a stage left empty clears its v bit; data registers may retain stale values. Outputs are only meaningful when out_valid=1.
- Backpressure: with out_ready=0, the pipeline fills to STAGES entries, then in_ready=0. No operand is dropped or duplicated, and order is preserved.
- Simultaneous accept/retire with the pipe full: allowed, with no bubble inserted.
- Reset asserted mid-operation: all in-flight results are discarded immediately, and no out_valid is produced for them after reset release.
- STAGES=1: a fully combinational carry chain feeding a single output register; latency 1.
- Width rule: no internal width growth beyond WIDTH+1. The carry from slice to slice is 1 bit.

Decomposition:
- Shared package pipelined_adder_pkg:
  - localparam helper for slice width (CW = WIDTH/STAGES);
  - an elaboration-time check function for the divisibility rule.
- One sub-module: adder_slice, a combinational CW-bit ripple of full-adder cells.
  - Inputs: a, b, cin.
  - Outputs: s, cout, and c_msb_in (carry into the slice MSB, used by the top slice for ovf).
  - Instantiated STAGES times via generate.

Test Plan (WIDTH=8, STAGES=2, out_ready=1 unless stated):
- a=0x0F, b=0x01, ci=0, sub=0 -> 2 cycles later s=0x10, co=0, ovf=0, out_valid pulses 1 cycle.
- a=0xFF, b=0x01, ci=0 -> s=0x00, co=1, ovf=0; a=0x7F, b=0x00, ci=1 -> s=0x80, co=0, ovf=1.
- sub=1: a=0x05, b=0x07 -> s=0xFE, co=0, ovf=0; a=0x80, b=0x01 -> s=0x7F, co=1, ovf=1; ci=1 is ignored in both.
- Backpressure: out_ready=0, offer 4 back-to-back sets (0x01+0x01, 0x02+0x02, 0x03+0x03, 0x04+0x04) -> in_ready=0 after 2 accepted, s holds 0x02. Raise out_ready -> results 0x02, 0x04, 0x06, 0x08 in order, none lost.
- Throughput: 16 consecutive random sets with in_valid=1 -> in_ready stays 1, 16 consecutive out_valid cycles, each matching the reference model a+b+ci.
- Reset mid-flight: accept 2 sets, assert rst_n=0 for 1 cycle -> out_valid=0, s=0 immediately; after release, no stale result appears within 4 cycles.
